dmem_responder: RTL and testbench

Data-memory responder at the memory end of the processor's load/store interface. It accepts the processor's `MRE`/`MWE`, `addressData` and `storeData` outputs and returns `loadedData`. The data array is single-ported, so stores are posted into a small write buffer that drains into the array on cycles with no read. Loads return combinationally in the same cycle, with store-to-load forwarding from the buffer.

---
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port array fronted by a posted-store write buffer with
// same-cycle load forwarding. Define DMEM_ALIGN_CHECK_EN to add the sticky `err` output.
module dmem_responder #(
    parameter int mbus = 32,
    parameter int AW   = 10,
    parameter int WBUF = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MRE,
    input  logic            MWE,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    output logic [mbus-1:0] loadedData,
    output logic            busy
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam int PW = $clog2(WBUF);
    localparam int CW = PW + 1;

    logic [mbus-1:0] mem     [2**AW];
    logic [AW-1:0]   wb_idx  [WBUF];
    logic [mbus-1:0] wb_data [WBUF];

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic [AW-1:0]   idx;
    logic            rd_req;
    logic            enq;
    logic            drain;
    logic            fwd_hit;
    logic [mbus-1:0] fwd_data;

    assign idx    = addressData[AW+1:2];
    assign rd_req = MRE & ~MWE;
    assign enq    = MWE;
    // A simultaneous MRE/MWE is a store, so it may drain; this keeps a full buffer from overflowing.
    assign drain  = (count_q != '0) & ~rd_req;
    assign busy   = (count_q != '0);

    logic unused_addr;
    assign unused_addr = ^{addressData[mbus-1:AW+2], addressData[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq)   tail_q <= tail_q + 1'b1;
            if (drain) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(enq) - CW'(drain);
        end
    end

    // Reset clears count asynchronously, so no drain write can occur while rst is low.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_idx[tail_q]  <= idx;
            wb_data[tail_q] <= storeData;
        end
        if (drain) mem[wb_idx[head_q]] <= wb_data[head_q];
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF; i++) begin
            logic [PW-1:0] slot;
            slot = head_q + PW'(i);
            if ((CW'(i) < count_q) && (wb_idx[slot] == idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    always_comb begin
        loadedData = '0;
        if (rst && rd_req) loadedData = fwd_hit ? fwd_data : mem[idx];
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (((MRE | MWE) & (addressData[1:0] != 2'b00)) | (MRE & MWE)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic checked
// against a queue-and-array reference model.
module tb_dmem_responder;

    localparam int MBUS = 32;
    localparam int AW   = 10;
    localparam int WBUF = 4;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MRE = 1'b0;
    logic        MWE = 1'b0;
    logic [31:0] addressData = '0;
    logic [31:0] storeData = '0;
    logic [31:0] loadedData;
    logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err;
`endif

    ent_t        wq[$];
    logic [31:0] mem_m [1 << AW];
    bit          mem_v [1 << AW];
    bit          err_m = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] obs_data;
    logic        obs_busy;

    always #5 clk = ~clk;

    dmem_responder #(
        .mbus(MBUS),
        .AW  (AW),
        .WBUF(WBUF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MRE        (MRE),
        .MWE        (MWE),
        .addressData(addressData),
        .storeData  (storeData),
        .loadedData (loadedData),
        .busy       (busy)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Youngest buffered store to idx wins, else the array word; returns 0 if the word is unknown.
    function automatic bit model_load(input int unsigned idx, output logic [31:0] d);
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].idx == idx) begin
                d = wq[i].data;
                return 1'b1;
            end
        end
        d = mem_m[idx];
        return mem_v[idx];
    endfunction

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit mre, input bit mwe, input logic [31:0] addr,
                        input logic [31:0] data);
        int unsigned idx;
        logic [31:0] exp;
        bit          known;
        ent_t        e;
        idx         = int'(addr[AW+1:2]);
        MRE         = mre;
        MWE         = mwe;
        addressData = addr;
        storeData   = data;
        known       = 1'b1;
        exp         = '0;
        if (mre && !mwe) known = model_load(idx, exp);
        @(negedge clk);
        obs_data = loadedData;
        obs_busy = busy;
        if (known) check("load", loadedData, exp);
        check("busy", 32'(busy), 32'(wq.size() != 0));
`ifdef DMEM_ALIGN_CHECK_EN
        check("err", 32'(err), 32'(err_m));
`endif
        @(posedge clk);
        if (wq.size() != 0 && (!mre || mwe)) begin
            e = wq.pop_front();
            mem_m[e.idx] = e.data;
            mem_v[e.idx] = 1'b1;
        end
        if (mwe) begin
            e.idx  = idx;
            e.data = data;
            wq.push_back(e);
        end
        if (((mre || mwe) && addr[1:0] != 2'b00) || (mre && mwe)) err_m = 1'b1;
        #1;
    endtask

    task automatic rst_pulse();
        rst         = 1'b0;
        MRE         = 1'b1;
        MWE         = 1'b0;
        addressData = 32'h40;
        wq.delete();
        err_m = 1'b0;
        @(negedge clk);
        check("rst_data", loadedData, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("rst_err", 32'(err), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        for (int i = 0; i < (1 << AW); i++) mem_v[i] = 1'b0;

        MRE = 1'b1;
        addressData = 32'h40;
        @(negedge clk);
        check("init_data", loadedData, 32'h0);
        check("init_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Store then immediate load: forwarded from the buffer.
        step(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        step(1'b1, 1'b0, 32'h40, 32'h0);
        check("fwd_data", obs_data, 32'hDEADBEEF);
        check("fwd_busy", 32'(obs_busy), 32'h1);

        // More stores than buffer entries, then drain and read back.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i * 4), 32'(i + 1));
        repeat (6) step(1'b0, 1'b0, 32'h0, 32'h0);
        check("drained_busy", 32'(obs_busy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'h0);
            check("seq_data", obs_data, 32'(i + 1));
        end

        // Continuous reads stall draining; forwarding keeps them correct.
        step(1'b0, 1'b1, 32'h80, 32'h11);
        step(1'b0, 1'b1, 32'h80, 32'h22);
        repeat (10) begin
            step(1'b1, 1'b0, 32'h80, 32'h0);
            check("hold_data", obs_data, 32'h22);
            check("hold_busy", 32'(obs_busy), 32'h1);
        end
        repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h80, 32'h0);
        check("hold_array", obs_data, 32'h22);
        check("hold_idle", 32'(obs_busy), 32'h0);

        // Read from the array after a fully drained store.
        step(1'b0, 1'b1, 32'h4, 32'h5A5A);
        repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h4, 32'h0);
        check("array_data", obs_data, 32'h5A5A);

        // Reset discards the undrained store; the array keeps the old word.
        step(1'b0, 1'b1, 32'h100, 32'hA0);
        step(1'b0, 1'b1, 32'h104, 32'hA1);
        step(1'b0, 1'b1, 32'h108, 32'hA2);
        repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h100, 32'hB0);
        step(1'b0, 1'b1, 32'h104, 32'hB1);
        step(1'b0, 1'b1, 32'h108, 32'hB2);
        rst_pulse();
        step(1'b1, 1'b0, 32'h100, 32'h0);
        check("rst_drained0", obs_data, 32'hB0);
        step(1'b1, 1'b0, 32'h104, 32'h0);
        check("rst_drained1", obs_data, 32'hB1);
        step(1'b1, 1'b0, 32'h108, 32'h0);
        check("rst_lost", obs_data, 32'hA2);

`ifdef DMEM_ALIGN_CHECK_EN
        step(1'b1, 1'b0, 32'h42, 32'h0);
        check("misalign_data", obs_data, 32'hDEADBEEF);
        check("err_set", 32'(err), 32'h1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
        check("err_sticky", 32'(err), 32'h1);
        rst_pulse();
        check("err_clear", 32'(err), 32'h0);
`endif

        // Random traffic over a small aliased window.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom);
        repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            a = {$urandom_range(0, 15) << 12};
            a = a | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 19);
            if (n == 200) rst_pulse();
            if (r < 9)       step(1'b1, 1'b0, a, 32'h0);
            else if (r < 16) step(1'b0, 1'b1, a, $urandom);
            else if (r < 19) step(1'b0, 1'b0, a, 32'h0);
            else             step(1'b1, 1'b1, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
